// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency SRAM port between instruction fetch and MEM-stage data accesses.
// One grant per cycle, in-order responses per requester, bounded fetch starvation.
module sram_port_arbiter #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [2:0]  data_mode,
  input  logic        data_us,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [2:0]  sram_mode,
  output logic        sram_us,
  input  logic [31:0] sram_rdata
);

  localparam logic [2:0] LAT_C    = 3'(LATENCY);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  logic [2:0] cnt_r;
  logic       owner_r;
  logic       owner_we_r;
  logic [3:0] starve_r;
  logic       can_grant_s;
  logic       resp_s;
  logic       inst_win_s;
  logic       data_win_s;

  // Pick a winner; data has priority until the fetch side has been passed over STARVE_MAX times
  always_comb begin
    inst_win_s  = 1'b0;
    data_win_s  = 1'b0;
    can_grant_s = !reset && ((cnt_r == 3'd0) || (cnt_r == 3'd1));
    if (can_grant_s) begin
      if (inst_req && data_req) begin
        if (starve_r == STARVE_C) begin
          inst_win_s = 1'b1;
        end else begin
          data_win_s = 1'b1;
        end
      end else begin
        inst_win_s = inst_req;
        data_win_s = data_req;
      end
    end else begin
      inst_win_s = 1'b0;
      data_win_s = 1'b0;
    end
  end

  // Drive grants and the SRAM command from the winner
  always_comb begin
    inst_gnt   = 1'b0;
    data_gnt   = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = 32'h0000_0000;
    sram_wdata = 32'h0000_0000;
    sram_mode  = 3'b000;
    sram_us    = 1'b0;
    case ({inst_win_s, data_win_s})
      2'b10: begin
        inst_gnt  = 1'b1;
        sram_en   = 1'b1;
        sram_addr = inst_addr;
        sram_mode = 3'b010;
      end
      2'b01: begin
        data_gnt   = 1'b1;
        sram_en    = 1'b1;
        sram_we    = data_we;
        sram_addr  = data_addr;
        sram_wdata = data_wdata;
        sram_mode  = data_mode;
        sram_us    = data_us;
      end
      default: begin
        sram_en = 1'b0;
      end
    endcase
  end

  // Route the returning SRAM word to whoever owns the outstanding access
  always_comb begin
    resp_s      = !reset && (cnt_r == 3'd1);
    inst_rvalid = resp_s && !owner_r;
    data_rvalid = resp_s && owner_r;
    if (inst_rvalid) begin
      inst_rdata = sram_rdata;
    end else begin
      inst_rdata = 32'h0000_0000;
    end
    if (data_rvalid && !owner_we_r) begin
      data_rdata = sram_rdata;
    end else begin
      data_rdata = 32'h0000_0000;
    end
  end

  // Outstanding-access countdown, ownership and fetch starvation tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= 3'd0;
      owner_r    <= 1'b0;
      owner_we_r <= 1'b0;
      starve_r   <= 4'd0;
    end else begin
      if (inst_win_s || data_win_s) begin
        cnt_r      <= LAT_C;
        owner_r    <= data_win_s;
        owner_we_r <= data_win_s && data_we;
      end else if (cnt_r != 3'd0) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if (inst_win_s || !inst_req) begin
        starve_r <= 4'd0;
      end else if (data_win_s && (starve_r < STARVE_C)) begin
        starve_r <= starve_r + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: instance a runs LATENCY=1, instance b LATENCY=3.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        a_reset, a_inst_req, a_inst_gnt, a_inst_rvalid, a_data_req, a_data_we, a_data_us;
  logic        a_data_gnt, a_data_rvalid, a_sram_en, a_sram_we, a_sram_us;
  logic [31:0] a_inst_addr, a_inst_rdata, a_data_addr, a_data_wdata, a_data_rdata;
  logic [31:0] a_sram_addr, a_sram_wdata, a_sram_rdata;
  logic [2:0]  a_data_mode, a_sram_mode;

  logic        b_reset, b_inst_req, b_inst_gnt, b_inst_rvalid, b_data_req, b_data_we, b_data_us;
  logic        b_data_gnt, b_data_rvalid, b_sram_en, b_sram_we, b_sram_us;
  logic [31:0] b_inst_addr, b_inst_rdata, b_data_addr, b_data_wdata, b_data_rdata;
  logic [31:0] b_sram_addr, b_sram_wdata, b_sram_rdata;
  logic [2:0]  b_data_mode, b_sram_mode;

  sram_port_arbiter #(.LATENCY(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(a_reset),
    .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_gnt(a_inst_gnt),
    .inst_rvalid(a_inst_rvalid), .inst_rdata(a_inst_rdata),
    .data_req(a_data_req), .data_we(a_data_we), .data_addr(a_data_addr),
    .data_wdata(a_data_wdata), .data_mode(a_data_mode), .data_us(a_data_us),
    .data_gnt(a_data_gnt), .data_rvalid(a_data_rvalid), .data_rdata(a_data_rdata),
    .sram_en(a_sram_en), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
    .sram_wdata(a_sram_wdata), .sram_mode(a_sram_mode), .sram_us(a_sram_us),
    .sram_rdata(a_sram_rdata));

  sram_port_arbiter #(.LATENCY(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(b_reset),
    .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_gnt(b_inst_gnt),
    .inst_rvalid(b_inst_rvalid), .inst_rdata(b_inst_rdata),
    .data_req(b_data_req), .data_we(b_data_we), .data_addr(b_data_addr),
    .data_wdata(b_data_wdata), .data_mode(b_data_mode), .data_us(b_data_us),
    .data_gnt(b_data_gnt), .data_rvalid(b_data_rvalid), .data_rdata(b_data_rdata),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_mode(b_sram_mode), .sram_us(b_sram_us),
    .sram_rdata(b_sram_rdata));

  // SRAM models: unwritten words read as 0xC0DE_0000 | byte address
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hC0DE_0000 | {20'h0_0000, a[11:2], 2'b00};
  endfunction

  logic [31:0] a_pipe = 32'h0;
  always @(posedge clk) a_pipe <= (a_sram_en && !a_sram_we) ? dflt(a_sram_addr) : 32'hBAD0_BAD0;
  assign a_sram_rdata = a_pipe;

  logic [1023:0] b_wr = '0;
  logic [31:0]   b_mem [0:1023];
  logic [31:0]   b_pipe0 = 32'h0, b_pipe1 = 32'h0, b_pipe2 = 32'h0;
  always @(posedge clk) begin
    if (b_sram_en && b_sram_we) begin
      b_mem[b_sram_addr[11:2]] <= b_sram_wdata;
      b_wr[b_sram_addr[11:2]]  <= 1'b1;
    end
    if (b_sram_en && !b_sram_we)
      b_pipe0 <= b_wr[b_sram_addr[11:2]] ? b_mem[b_sram_addr[11:2]] : dflt(b_sram_addr);
    else
      b_pipe0 <= 32'hBAD0_BAD0;
    b_pipe1 <= b_pipe0;
    b_pipe2 <= b_pipe1;
  end
  assign b_sram_rdata = b_pipe2;

  // expected responses: {due cycle, rdata}
  logic [63:0] aq_i[$], aq_d[$], bq_i[$], bq_d[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  logic [63:0] me;
  always @(negedge clk) begin
    if (a_inst_rvalid) begin
      if (aq_i.size() == 0) chk("a_inst_unexpected_rvalid", 32'd1, 32'd0);
      else begin me = aq_i.pop_front(); chk("a_inst_rdata", a_inst_rdata, me[31:0]); chk("a_inst_rcycle", 32'(cyc), me[63:32]); end
    end
    if (a_data_rvalid) begin
      if (aq_d.size() == 0) chk("a_data_unexpected_rvalid", 32'd1, 32'd0);
      else begin me = aq_d.pop_front(); chk("a_data_rdata", a_data_rdata, me[31:0]); chk("a_data_rcycle", 32'(cyc), me[63:32]); end
    end
    if (b_inst_rvalid) begin
      if (bq_i.size() == 0) chk("b_inst_unexpected_rvalid", 32'd1, 32'd0);
      else begin me = bq_i.pop_front(); chk("b_inst_rdata", b_inst_rdata, me[31:0]); chk("b_inst_rcycle", 32'(cyc), me[63:32]); end
    end
    if (b_data_rvalid) begin
      if (bq_d.size() == 0) chk("b_data_unexpected_rvalid", 32'd1, 32'd0);
      else begin me = bq_d.pop_front(); chk("b_data_rdata", b_data_rdata, me[31:0]); chk("b_data_rcycle", 32'(cyc), me[63:32]); end
    end
    if (a_inst_gnt && a_data_gnt) chk("a_gnt_exclusive", 32'd1, 32'd0);
    if (b_inst_gnt && b_data_gnt) chk("b_gnt_exclusive", 32'd1, 32'd0);
    if (a_inst_gnt && !a_inst_req) chk("a_inst_gnt_without_req", 32'd1, 32'd0);
    if (a_data_gnt && !a_data_req) chk("a_data_gnt_without_req", 32'd1, 32'd0);
    if (b_inst_gnt && !b_inst_req) chk("b_inst_gnt_without_req", 32'd1, 32'd0);
    if (b_data_gnt && !b_data_req) chk("b_data_gnt_without_req", 32'd1, 32'd0);
  end

  // Raise one request, wait (bounded) for its grant, check the SRAM command, queue the response
  task automatic do_req(input bit sel_b, input bit is_data, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] mode, input logic [31:0] exp,
                        output int gcyc);
    int   lat;
    logic g;
    lat = sel_b ? 3 : 1;
    if (sel_b) begin
      if (is_data) begin b_data_req = 1'b1; b_data_we = we; b_data_addr = addr; b_data_wdata = wdata; b_data_mode = mode; end
      else begin b_inst_req = 1'b1; b_inst_addr = addr; end
    end else begin
      if (is_data) begin a_data_req = 1'b1; a_data_we = we; a_data_addr = addr; a_data_wdata = wdata; a_data_mode = mode; end
      else begin a_inst_req = 1'b1; a_inst_addr = addr; end
    end
    gcyc = -1;
    for (int k = 0; k < 16 && gcyc < 0; k++) begin
      @(negedge clk);
      g = sel_b ? (is_data ? b_data_gnt : b_inst_gnt) : (is_data ? a_data_gnt : a_inst_gnt);
      if (g) begin
        gcyc = cyc;
        if (sel_b) begin
          if (is_data) bq_d.push_back({cyc + lat, exp}); else bq_i.push_back({cyc + lat, exp});
        end else begin
          if (is_data) aq_d.push_back({cyc + lat, exp}); else aq_i.push_back({cyc + lat, exp});
        end
        chk("gnt_sram_en", 32'(sel_b ? b_sram_en : a_sram_en), 32'd1);
        chk("gnt_sram_addr", sel_b ? b_sram_addr : a_sram_addr, addr);
        chk("gnt_sram_we", 32'(sel_b ? b_sram_we : a_sram_we), 32'(is_data & we));
        chk("gnt_sram_mode", 32'(sel_b ? b_sram_mode : a_sram_mode), 32'(is_data ? mode : 3'b010));
        if (is_data && we) chk("gnt_sram_wdata", sel_b ? b_sram_wdata : a_sram_wdata, wdata);
      end
      @(posedge clk); #1;
    end
    if (gcyc < 0) chk("gnt_timeout", 32'd0, 32'd1);
    if (sel_b) begin if (is_data) b_data_req = 1'b0; else b_inst_req = 1'b0; end
    else begin if (is_data) a_data_req = 1'b0; else a_inst_req = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int    g1, g2, g3, rel;
    byte   got;
    string order;
    order = "DDDDIDDDDI";
    a_reset = 1'b1; b_reset = 1'b1;
    a_inst_req = 1'b1; a_inst_addr = 32'h0000_0040;
    a_data_req = 1'b1; a_data_we = 1'b0; a_data_addr = 32'h0000_0010;
    a_data_wdata = 32'h0; a_data_mode = 3'b010; a_data_us = 1'b0;
    b_inst_req = 1'b0; b_inst_addr = 32'h0; b_data_req = 1'b0; b_data_we = 1'b0;
    b_data_addr = 32'h0; b_data_wdata = 32'h0; b_data_mode = 3'b010; b_data_us = 1'b0;

    // reset with both requests high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({a_inst_gnt, a_data_gnt}), 32'd0);
    chk("rst_sram_en_we", 32'({a_sram_en, a_sram_we}), 32'd0);
    chk("rst_sram_addr", a_sram_addr, 32'd0);
    chk("rst_rvalid", 32'({a_inst_rvalid, a_data_rvalid}), 32'd0);
    @(posedge clk); #1;
    a_reset = 1'b0; b_reset = 1'b0; rel = cyc;
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b010, 32'hC0DE_0010, g1);
    a_inst_req = 1'b0;
    chk("rst_release_first_gnt_cycle", 32'(g1), 32'(rel));

    // LATENCY=1 back-to-back fetches, with junk on the idle data fields
    a_data_we = 1'b1; a_data_mode = 3'b101; a_data_wdata = 32'h1234_5678;
    do_req(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 3'b000, 32'hC0DE_0000, g1);
    do_req(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 3'b000, 32'hC0DE_0004, g2);
    do_req(1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 3'b000, 32'hC0DE_0008, g3);
    chk("fetch_b2b_gap1", 32'(g2 - g1), 32'd1);
    chk("fetch_b2b_gap2", 32'(g3 - g2), 32'd1);

    // starvation bound with both requests held
    a_inst_req = 1'b1; a_inst_addr = 32'h0000_0020;
    a_data_req = 1'b1; a_data_we = 1'b0; a_data_addr = 32'h0000_0030; a_data_mode = 3'b010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got = a_data_gnt ? 8'h44 : (a_inst_gnt ? 8'h49 : 8'h2D);
      if (a_data_gnt) aq_d.push_back({cyc + 1, 32'hC0DE_0030});
      if (a_inst_gnt) aq_i.push_back({cyc + 1, 32'hC0DE_0020});
      chk($sformatf("starve_order_%0d", k), 32'(got), 32'(order[k]));
      @(posedge clk); #1;
    end
    a_inst_req = 1'b0; a_data_req = 1'b0;

    // LATENCY=3 back-to-back loads
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'hC0DE_0100, g1);
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0180, 32'h0, 3'b010, 32'hC0DE_0180, g2);
    chk("lat3_second_gnt_gap", 32'(g2 - g1), 32'd3);

    // store then load back
    do_req(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 3'b010, 32'h0, g1);
    @(negedge clk);
    chk("store_we_single_cycle", 32'(b_sram_we), 32'd0);
    @(posedge clk); #1;
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b010, 32'hDEAD_BEEF, g2);

    // reset pulse right after a load grant drops the response
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'hC0DE_0100, g1);
    b_reset = 1'b1;
    bq_d.delete();
    @(negedge clk);
    chk("midrst_outputs", 32'({b_sram_en, b_data_rvalid, b_inst_rvalid, b_data_gnt}), 32'd0);
    @(posedge clk); #1;
    b_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_rvalid_at_T3", 32'(b_data_rvalid), 32'd0);
    @(posedge clk); #1;
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 3'b010, 32'hC0DE_0104, g2);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_aq_i", 32'(aq_i.size()), 32'd0);
    chk("drain_aq_d", 32'(aq_d.size()), 32'd0);
    chk("drain_bq_i", 32'(bq_i.size()), 32'd0);
    chk("drain_bq_d", 32'(bq_d.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
